// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared constants, opcode encodings and request/response types for the ALU arbiter
package alu_arb_pkg;
    localparam int NUM_REQ   = 2;
    localparam int DEF_TAG_W = 4;
    localparam int DEF_CNT_W = 16;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef struct packed {
        logic [6:0]           opcode;
        logic [2:0]           func3;
        logic [6:0]           func7;
        logic [31:0]          op1;
        logic [31:0]          op2;
        logic [DEF_TAG_W-1:0] tag;
    } alu_req_t;

    typedef struct packed {
        logic [31:0]          data;
        logic [DEF_TAG_W-1:0] tag;
    } alu_rsp_t;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational integer ALU; unsupported opcodes produce zero
module alu
    import alu_arb_pkg::*;
(
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_func3,
    input  logic [6:0]  i_func7,
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    output logic [31:0] o_result
);
    logic              w_alt;
    logic [4:0]        w_shamt;
    logic signed [31:0] w_sra;
    logic              w_unused_func7;

    assign w_alt          = i_func7[5];
    assign w_shamt        = i_op2[4:0];
    assign w_unused_func7 = ^{i_func7[6], i_func7[4:0]};
    // kept separate so the arithmetic shift is not coerced to unsigned by the mux
    assign w_sra          = $signed(i_op1) >>> w_shamt;

    always_comb begin
        o_result = '0;
        if (i_opcode == OP_R || i_opcode == OP_I) begin
            case (i_func3)
                F3_ADD:  o_result = (i_opcode == OP_R && w_alt) ? i_op1 - i_op2 : i_op1 + i_op2;
                F3_SLL:  o_result = i_op1 << w_shamt;
                F3_SLT:  o_result = {31'b0, $signed(i_op1) < $signed(i_op2)};
                F3_SLTU: o_result = {31'b0, i_op1 < i_op2};
                F3_XOR:  o_result = i_op1 ^ i_op2;
                F3_SR:   o_result = w_alt ? $unsigned(w_sra) : i_op1 >> w_shamt;
                F3_OR:   o_result = i_op1 | i_op2;
                F3_AND:  o_result = i_op1 & i_op2;
            endcase
        end
    end

endmodule

// File: rtl/alu_arb_pick.sv
// rtl/alu_arb_pick.sv - one-hot grant from eligible requesters
// ALU_ARB_RR_EN selects round-robin on conflict; otherwise requester 0 has fixed priority.
module alu_arb_pick
    import alu_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_eligible,
    input  logic               i_last_grant,
    output logic [NUM_REQ-1:0] o_grant
);

`ifdef ALU_ARB_RR_EN
    always_comb begin
        o_grant = i_eligible;
        if (i_eligible == 2'b11) begin
            o_grant = i_last_grant ? 2'b01 : 2'b10;
        end
    end
`else
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;

    always_comb begin
        o_grant = i_eligible;
        if (i_eligible == 2'b11) begin
            o_grant = 2'b01;
        end
    end
`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between two requesters with 1-entry response slots
// ALU_ARB_RR_EN (see alu_arb_pick) switches conflict resolution to round-robin.
module alu_share_arbiter
    import alu_arb_pkg::*;
#(
    parameter int TAG_W = DEF_TAG_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic [NUM_REQ-1:0][6:0]       i_req_opcode,
    input  logic [NUM_REQ-1:0][2:0]       i_req_func3,
    input  logic [NUM_REQ-1:0][6:0]       i_req_func7,
    input  logic [NUM_REQ-1:0][31:0]      i_req_op1,
    input  logic [NUM_REQ-1:0][31:0]      i_req_op2,
    input  logic [NUM_REQ-1:0][TAG_W-1:0] i_req_tag,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    input  logic [NUM_REQ-1:0]            i_rsp_ready,
    output logic [NUM_REQ-1:0][31:0]      o_rsp_data,
    output logic [NUM_REQ-1:0][TAG_W-1:0] o_rsp_tag,
    output logic [CNT_W-1:0]              o_contention_cnt
);
    logic                      r_active;
    logic                      r_last_grant;
    logic [CNT_W-1:0]          r_cnt;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    alu_rsp_t [NUM_REQ-1:0]    r_slot;

    logic [NUM_REQ-1:0]        w_eligible;
    logic [NUM_REQ-1:0]        w_grant;
    logic                      w_idx;
    alu_req_t                  w_sel;
    logic [31:0]               w_alu_res;

    // r_active holds off grants until the first edge after reset release
    assign w_eligible = {NUM_REQ{r_active}} & i_req_valid & (~r_rsp_valid | i_rsp_ready);

    alu_arb_pick u_pick (
        .i_eligible   (w_eligible),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_idx       = w_grant[1];
    assign o_req_ready = w_grant;

    always_comb begin
        w_sel.opcode = i_req_opcode[w_idx];
        w_sel.func3  = i_req_func3[w_idx];
        w_sel.func7  = i_req_func7[w_idx];
        w_sel.op1    = i_req_op1[w_idx];
        w_sel.op2    = i_req_op2[w_idx];
        w_sel.tag    = i_req_tag[w_idx];
    end

    alu u_alu (
        .i_opcode (w_sel.opcode),
        .i_func3  (w_sel.func3),
        .i_func7  (w_sel.func7),
        .i_op1    (w_sel.op1),
        .i_op2    (w_sel.op2),
        .o_result (w_alu_res)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active     <= 1'b0;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_rsp_valid  <= '0;
            r_slot       <= '0;
        end else begin
            r_active <= 1'b1;
            if (|w_grant) begin
                r_last_grant <= w_idx;
            end
            if (w_eligible == 2'b11 && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_rsp_valid[i]  <= 1'b1;
                    r_slot[i].data  <= w_alu_res;
                    r_slot[i].tag   <= w_sel.tag;
                end else if (i_rsp_ready[i]) begin
                    r_rsp_valid[i]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        o_rsp_data = '0;
        o_rsp_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_rsp_data[i] = r_slot[i].data;
            o_rsp_tag[i]  = r_slot[i].tag;
        end
    end

    assign o_rsp_valid      = r_rsp_valid;
    assign o_contention_cnt = r_cnt;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    localparam logic [6:0] OP_R = 7'h33;
    localparam logic [6:0] OP_I = 7'h13;

    localparam int NV = 9;
    localparam logic [6:0]  V_OPC [NV] = '{7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h33, 7'h13, 7'h13, 7'h7F};
    localparam logic [2:0]  V_F3  [NV] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd5, 3'd6, 3'd0, 3'd0, 3'd0};
    localparam logic [6:0]  V_F7  [NV] = '{7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00};
    localparam logic [31:0] V_A   [NV] = '{32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                                           32'hF0, 32'd5, 32'd5, 32'd9};
    localparam logic [31:0] V_B   [NV] = '{32'd4, 32'd1, 32'd1, 32'd4, 32'd4, 32'h0F, 32'hFFFFFFFF,
                                           32'hFFFFFFFF, 32'd9};
    localparam logic [31:0] V_EXP [NV] = '{32'd16, 32'd1, 32'd0, 32'hF8000000, 32'h08000000, 32'hFF,
                                           32'd4, 32'd4, 32'd0};

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [1:0]       req_valid = '0;
    logic [1:0]       req_ready;
    logic [1:0][6:0]  req_opcode = '0;
    logic [1:0][2:0]  req_func3 = '0;
    logic [1:0][6:0]  req_func7 = '0;
    logic [1:0][31:0] req_op1 = '0;
    logic [1:0][31:0] req_op2 = '0;
    logic [1:0][3:0]  req_tag = '0;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready = '0;
    logic [1:0][31:0] rsp_data;
    logic [1:0][3:0]  rsp_tag;
    logic [15:0]      cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.TAG_W(4), .CNT_W(16)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_opcode     (req_opcode),
        .i_req_func3      (req_func3),
        .i_req_func7      (req_func7),
        .i_req_op1        (req_op1),
        .i_req_op2        (req_op2),
        .i_req_tag        (req_tag),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_data       (rsp_data),
        .o_rsp_tag        (rsp_tag),
        .o_contention_cnt (cnt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rsp_ready = '0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int i, input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        req_opcode[i] = opc;
        req_func3[i]  = f3;
        req_func7[i]  = f7;
        req_op1[i]    = a;
        req_op2[i]    = b;
        req_tag[i]    = tag;
    endtask

    task automatic test_reset();
        req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #11;
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", rsp_valid); end
        n_tests++; if (rsp_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", rsp_data); end
        n_tests++; if (rsp_tag !== 8'd0) begin n_fail++; $display("FAIL reset_tag: got %h want 0", rsp_tag); end
        n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", cnt); end
        do_reset();
    endtask

    task automatic test_single();
        set_req(0, OP_I, 3'd0, 7'h00, 32'd5, 32'd7, 4'd3);
        req_valid = 2'b01;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        n_tests++; if (rsp_valid !== 2'b01) begin n_fail++; $display("FAIL single_valid: got %b want 01", rsp_valid); end
        n_tests++; if (rsp_data[0] !== 32'd12) begin n_fail++; $display("FAIL single_data: got %0d want 12", rsp_data[0]); end
        n_tests++; if (rsp_tag[0] !== 4'd3) begin n_fail++; $display("FAIL single_tag: got %0d want 3", rsp_tag[0]); end
    endtask

    task automatic test_alu_ops();
        rsp_ready = 2'b11;
        for (int k = 0; k < NV; k++) begin
            set_req(1, V_OPC[k], V_F3[k], V_F7[k], V_A[k], V_B[k], 4'(k));
            req_valid = 2'b10;
            tick();
            n_tests++;
            if (rsp_valid[1] !== 1'b1 || rsp_data[1] !== V_EXP[k] || rsp_tag[1] !== 4'(k)) begin
                n_fail++;
                $display("FAIL alu_op[%0d]: got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                         k, rsp_valid[1], rsp_data[1], rsp_tag[1], V_EXP[k], k);
            end
        end
        req_valid = 2'b00;
        tick();
    endtask

    task automatic test_conflict();
        logic [1:0] exp;
        do_reset();
        set_req(0, OP_R, 3'd0, 7'h00, 32'd1, 32'd2, 4'd1);
        set_req(1, OP_R, 3'd4, 7'h00, 32'hFF, 32'h0F, 4'd2);
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp = 2'b01;
`endif
            #1;
            n_tests++; if (req_ready !== exp) begin n_fail++; $display("FAIL conflict_grant[%0d]: got %b want %b", k, req_ready, exp); end
            tick();
        end
        req_valid = 2'b00;
        n_tests++; if (cnt !== 16'd4) begin n_fail++; $display("FAIL conflict_cnt: got %0d want 4", cnt); end
`ifdef ALU_ARB_RR_EN
        n_tests++; if (rsp_valid !== 2'b10 || rsp_data[1] !== 32'hF0) begin
            n_fail++; $display("FAIL conflict_rsp: got v=%b d1=%h want v=10 d1=f0", rsp_valid, rsp_data[1]); end
`else
        n_tests++; if (rsp_valid !== 2'b01 || rsp_data[0] !== 32'd3) begin
            n_fail++; $display("FAIL conflict_rsp: got v=%b d0=%h want v=01 d0=3", rsp_valid, rsp_data[0]); end
`endif
    endtask

    task automatic test_back_pressure();
        do_reset();
        rsp_ready = 2'b00;
        set_req(0, OP_I, 3'd0, 7'h00, 32'd100, 32'd1, 4'd5);
        req_valid = 2'b01;
        tick();
        set_req(0, OP_R, 3'd0, 7'h20, 32'd10, 32'd3, 4'd2);
        set_req(1, OP_R, 3'd7, 7'h00, 32'hF0, 32'h3C, 4'd9);
        req_valid = 2'b11;
        #1;
        n_tests++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant: got %b want 10", req_ready); end
        tick();
        n_tests++; if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL bp_valid: got %b want 11", rsp_valid); end
        n_tests++; if (rsp_data[0] !== 32'd101 || rsp_tag[0] !== 4'd5) begin
            n_fail++; $display("FAIL bp_hold0: got d=%0d t=%0d want d=101 t=5", rsp_data[0], rsp_tag[0]); end
        n_tests++; if (rsp_data[1] !== 32'h30 || rsp_tag[1] !== 4'd9) begin
            n_fail++; $display("FAIL bp_slot1: got d=%h t=%0d want d=30 t=9", rsp_data[1], rsp_tag[1]); end
        n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL bp_cnt: got %0d want 0", cnt); end
    endtask

    task automatic test_drain_refill();
        req_valid = 2'b01;
        rsp_ready = 2'b01;
        #1;
        n_tests++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL refill_grant: got %b want 01", req_ready); end
        tick();
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        n_tests++; if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL refill_valid: got %b want 11", rsp_valid); end
        n_tests++; if (rsp_data[0] !== 32'd7 || rsp_tag[0] !== 4'd2) begin
            n_fail++; $display("FAIL refill_data: got d=%0d t=%0d want d=7 t=2", rsp_data[0], rsp_tag[0]); end
        n_tests++; if (rsp_data[1] !== 32'h30) begin n_fail++; $display("FAIL refill_other: got %h want 30", rsp_data[1]); end
        rsp_ready = 2'b11;
        tick();
        rsp_ready = 2'b00;
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL drain_valid: got %b want 00", rsp_valid); end
    endtask

    task automatic test_saturate();
        do_reset();
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        repeat (65534) @(posedge clk);
        @(negedge clk);
        n_tests++; if (cnt !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe: got %h want fffe", cnt); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++; if (cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff: got %h want ffff", cnt); end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 2'b00;
        req_valid = 2'b11;
        tick();
        tick();
        n_tests++; if (rsp_valid !== 2'b11) begin n_fail++; $display("FAIL mid_full: got %b want 11", rsp_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (rsp_valid !== 2'b00) begin n_fail++; $display("FAIL mid_valid: got %b want 00", rsp_valid); end
        n_tests++; if (rsp_data !== 64'd0) begin n_fail++; $display("FAIL mid_data: got %h want 0", rsp_data); end
        n_tests++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt: got %h want 0", cnt); end
        n_tests++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL mid_ready: got %b want 00", req_ready); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_alu_ops();
        test_conflict();
        test_back_pressure();
        test_drain_refill();
        test_saturate();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
